main_memory_ctrl: RTL

//   Backing-store stage directly downstream of cache_controller. Serves the

---
 rtl/main_memory_ctrl_if.sv | 29 ++
 rtl/main_memory_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/main_memory_ctrl_if.sv
// Cache-side bus for the backing-store controller.
// Request/ready handshake plus burst read/write beat signals.
interface main_memory_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              mem_wready;
  logic              mem_done;
  logic              busy;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata, mem_rvalid,
    input  mem_wready, mem_done, busy
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata, mem_rvalid,
    output mem_wready, mem_done, busy
  );
endinterface

// File: rtl/main_memory_ctrl.sv
// Backing store behind the cache: fixed-latency line refill and
// write-back bursts over a word-addressed RAM.
module main_memory_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 4096,
  parameter int LATENCY   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  main_memory_ctrl_if.slave bus
);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int LINE_W = IDX_W - BEAT_W;
  localparam int LAT_W  = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RBURST,
    S_WBURST,
    S_DONE
  } state_t;

  logic [DATA_W-1:0] ram [MEM_DEPTH];

  state_t            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              we_q, we_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic              wready_q, wready_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [BEAT_W-1:0] beat_nx;
  logic              unused_addr;

  // byte offset and bits above the RAM depth never select a word
  assign unused_addr = ^bus.mem_addr;
  assign beat_nx     = beat_q + BEAT_W'(1);

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    we_d     = we_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    rdata_d  = rdata_q;
    ready_d  = ready_q;
    rvalid_d = rvalid_q;
    wready_d = wready_q;
    done_d   = done_q;
    busy_d   = busy_q;
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (bus.mem_req) begin
          state_d = S_WAIT;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          line_d  = bus.mem_addr[3+BEAT_W +: LINE_W];
          we_d    = bus.mem_we;
          lat_d   = LAT_W'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          state_d  = we_q ? S_WBURST : S_RBURST;
          beat_d   = '0;
          rvalid_d = !we_q;
          wready_d = we_q;
          if (!we_q) rdata_d = ram[{line_q, BEAT_W'(0)}];
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_RBURST, S_WBURST: begin
        if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
          state_d  = S_DONE;
          rvalid_d = 1'b0;
          wready_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          beat_d = beat_nx;
          if (state_q == S_RBURST) rdata_d = ram[{line_q, beat_nx}];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        ready_d  = 1'b1;
        rvalid_d = 1'b0;
        wready_d = 1'b0;
        done_d   = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      line_q   <= '0;
      we_q     <= 1'b0;
      lat_q    <= '0;
      beat_q   <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      wready_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      we_q     <= we_d;
      lat_q    <= lat_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      wready_q <= wready_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // RAM survives reset; wready drops with reset so a cut burst stops writing
  always_ff @(posedge clk) begin
    if (wready_q) ram[{line_q, beat_q}] <= bus.mem_wdata;
  end

  assign bus.mem_ready  = ready_q;
  assign bus.mem_rdata  = rdata_q;
  assign bus.mem_rvalid = rvalid_q;
  assign bus.mem_wready = wready_q;
  assign bus.mem_done   = done_q;
  assign bus.busy       = busy_q;
endmodule
